// File: rtl/mod_counter_updn.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_updn
// Purpose  : Loadable modulo-N up/down counter with a combinational terminal
//            count for cascading, a registered wrap pulse and a registered
//            load-clamp error pulse. The terminal value either wraps or
//            saturates, selected at elaboration.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter_updn #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 13,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] num,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guard: an illegal modulus stops the build
  // rather than producing a counter that can reach unreachable codes.
  // --------------------------------------------------------------------------
  if ((WIDTH < 1) || (WIDTH > 31)) begin : g_bad_width
    $error("mod_counter_updn: WIDTH must be in 1..31");
  end

  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("mod_counter_updn: MODULUS must be in 2..2**WIDTH");
  end

  // Highest legal count value; fits in WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam bit               c_sat  = (SATURATE != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_num;
  logic             r_wrap;
  logic             r_load_err;

  // Next-state values
  logic [WIDTH-1:0] w_num_next;
  logic             w_wrap_next;
  logic             w_load_err_next;

  // Decoded conditions
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_at_terminal;
  logic             w_in_over;

  assign w_at_max      = (r_num == c_max);
  assign w_at_zero     = (r_num == c_zero);
  // The terminal value depends on direction: top of range going up,
  // bottom of range going down.
  assign w_at_terminal = up ? w_at_max : w_at_zero;
  // A load value above the top of range is clamped rather than accepted,
  // so the register never holds a code >= MODULUS.
  assign w_in_over     = (in > c_max);

  // Next count and pulse sources; priority is load over enable over hold.
  always_comb begin
    w_num_next      = r_num;
    w_wrap_next     = 1'b0;
    w_load_err_next = 1'b0;

    if (load) begin
      // A load always wins, so a coincident terminal count never wraps.
      if (w_in_over) begin
        w_num_next      = c_max;
        w_load_err_next = 1'b1;
      end else begin
        w_num_next      = in;
      end
    end else if (enable) begin
      if (w_at_terminal) begin
        if (!c_sat) begin
          // Wrap to the opposite end of the range and flag it next cycle.
          w_num_next  = up ? c_zero : c_max;
          w_wrap_next = 1'b1;
        end
        // Saturating mode: hold at the terminal value, no wrap pulse.
      end else if (up) begin
        w_num_next = r_num + c_one;
      end else begin
        w_num_next = r_num - c_one;
      end
    end
  end

  // Count register and event pulses, cleared immediately by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_num      <= c_zero;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_num      <= w_num_next;
      r_wrap     <= w_wrap_next;
      r_load_err <= w_load_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. tc is combinational so a downstream stage sees it before the
  // same edge that advances this stage, giving a ripple-free cascade.
  // --------------------------------------------------------------------------
  assign num      = r_num;
  assign tc       = enable & w_at_terminal;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_updn.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter_updn
// Purpose  : Self-checking bench for mod_counter_updn. A wrapping and a
//            saturating instance (MODULUS=13) share one stimulus stream; a
//            two-stage MODULUS=10 cascade runs separately.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter_updn;

  localparam int c_m   = 13;
  localparam int c_mc  = 10;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] in;
  logic       enable;
  logic       up;

  logic [3:0] num_a, num_s;
  logic       tc_a, tc_s, wrap_a, wrap_s, lerr_a, lerr_s;

  logic       c_reset;
  logic [3:0] c_in;
  logic       c_en0;
  logic       c_up;
  logic       c_load;
  logic [3:0] num0, num1;
  logic       tc0, tc1, wrap0, wrap1, lerr0, lerr1;

  int total = 0;
  int bad   = 0;

  // Model state for the two MODULUS=13 instances
  int m_a;
  int m_s;

  typedef struct {
    int num_a; bit wrap_a; bit lerr_a;
    int num_s; bit wrap_s; bit lerr_s;
  } exp_t;
  exp_t sbq[$];

  typedef struct { int n0; int n1; } cexp_t;
  cexp_t cq[$];

  mod_counter_updn #(.WIDTH(4), .MODULUS(c_m), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .load(load), .in(in), .enable(enable), .up(up),
    .num(num_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
  );

  mod_counter_updn #(.WIDTH(4), .MODULUS(c_m), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .load(load), .in(in), .enable(enable), .up(up),
    .num(num_s), .tc(tc_s), .wrap(wrap_s), .load_err(lerr_s)
  );

  mod_counter_updn #(.WIDTH(4), .MODULUS(c_mc), .SATURATE(0)) u_stage0 (
    .clock(clock), .reset(c_reset), .load(c_load), .in(c_in), .enable(c_en0), .up(c_up),
    .num(num0), .tc(tc0), .wrap(wrap0), .load_err(lerr0)
  );

  mod_counter_updn #(.WIDTH(4), .MODULUS(c_mc), .SATURATE(0)) u_stage1 (
    .clock(clock), .reset(c_reset), .load(c_load), .in(c_in), .enable(tc0), .up(c_up),
    .num(num1), .tc(tc1), .wrap(wrap1), .load_err(lerr1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour of one counter for one edge.
  function automatic void model_step(input int m, input bit sat, input int cur,
                                     input bit ld, input int din, input bit en, input bit u,
                                     output int nxt, output bit w, output bit le);
    nxt = cur; w = 1'b0; le = 1'b0;
    if (ld) begin
      if (din >= m) begin nxt = m - 1; le = 1'b1; end
      else nxt = din;
    end else if (en) begin
      if (u) begin
        if (cur == m - 1) begin
          if (!sat) begin nxt = 0; w = 1'b1; end
        end else nxt = cur + 1;
      end else begin
        if (cur == 0) begin
          if (!sat) begin nxt = m - 1; w = 1'b1; end
        end else nxt = cur - 1;
      end
    end
  endfunction

  function automatic bit model_tc(input int m, input int cur, input bit en, input bit u);
    return en && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  // Drive one cycle of stimulus (entered just after a rising edge), check tc
  // before the edge, push the expected post-edge state and compare after it.
  task automatic cycle(input bit ld, input int din, input bit en, input bit u);
    exp_t e;
    int na, ns;
    bit wa, la, ws, ls;
    load = ld; in = 4'(din); enable = en; up = u;
    #1;
    chk("tc_wrap", 32'(tc_a), 32'(model_tc(c_m, m_a, en, u)));
    chk("tc_sat",  32'(tc_s), 32'(model_tc(c_m, m_s, en, u)));
    model_step(c_m, 1'b0, m_a, ld, din, en, u, na, wa, la);
    model_step(c_m, 1'b1, m_s, ld, din, en, u, ns, ws, ls);
    sbq.push_back('{na, wa, la, ns, ws, ls});
    m_a = na; m_s = ns;
    @(posedge clock); #1;
    e = sbq.pop_front();
    chk("num_wrap",  32'(num_a),  32'(e.num_a));
    chk("wrap_wrap", 32'(wrap_a), 32'(e.wrap_a));
    chk("lerr_wrap", 32'(lerr_a), 32'(e.lerr_a));
    chk("num_sat",   32'(num_s),  32'(e.num_s));
    chk("wrap_sat",  32'(wrap_s), 32'(e.wrap_s));
    chk("lerr_sat",  32'(lerr_s), 32'(e.lerr_s));
  endtask

  // Pulse reset between edges and check that it clears state without a clock.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    chk("async_num",  32'(num_a),  32'd0);
    chk("async_wrap", 32'(wrap_a), 32'd0);
    chk("async_lerr", 32'(lerr_a), 32'd0);
    chk("async_nums", 32'(num_s),  32'd0);
    #1 reset = 1'b0;
    m_a = 0; m_s = 0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; in = 4'd0; enable = 1'b0; up = 1'b1;
    c_reset = 1'b1; c_in = 4'd0; c_en0 = 1'b1; c_up = 1'b1; c_load = 1'b0;
    m_a = 0; m_s = 0;

    // Reset state, before any clock edge
    #1;
    chk("rst_num",  32'(num_a),  32'd0);
    chk("rst_wrap", 32'(wrap_a), 32'd0);
    chk("rst_lerr", 32'(lerr_a), 32'd0);
    chk("rst_nums", 32'(num_s),  32'd0);

    // Load and enable are ignored while reset is high; tc follows num=0
    load = 1'b1; in = 4'd5; enable = 1'b1; up = 1'b0;
    @(posedge clock); #1;
    chk("rst_ignload", 32'(num_a), 32'd0);
    chk("rst_tc_dn",   32'(tc_a),  32'd1);
    up = 1'b1; #1;
    chk("rst_tc_up",   32'(tc_a),  32'd0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;

    // Up wrap: 11 -> 12 -> 0 -> 1
    cycle(1, 11, 0, 1);
    repeat (3) cycle(0, 0, 1, 1);

    // Down wrap: 1 -> 0 -> 12 -> 11
    cycle(1, 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 0);

    // Clamp and range boundaries of the load value
    cycle(1, 15, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 13, 1, 1);
    cycle(1, 12, 0, 0);
    cycle(1, 0, 1, 0);

    // Saturation at the top: wrapping instance wraps, saturating one holds
    cycle(1, 12, 0, 1);
    repeat (5) cycle(0, 0, 1, 1);

    // Load coincident with terminal count suppresses wrap
    cycle(1, 12, 0, 1);
    cycle(1, 3, 1, 1);

    // Hold with enable low, then immediate direction changes
    repeat (2) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Async reset at num=7 while counting, then first edge counts to 1
    cycle(1, 7, 0, 1);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    pulse_reset();
    cycle(0, 0, 1, 1);

    // Async reset in the middle of a wrap pulse
    cycle(1, 12, 0, 1);
    cycle(0, 0, 1, 1);
    pulse_reset();
    cycle(0, 0, 1, 0);

    // Two-stage MODULUS=10 cascade, 100 edges from zero
    c_reset = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      chk("casc_tc0", 32'(tc0), 32'(((k - 1) % c_mc) == c_mc - 1));
      cq.push_back('{k % c_mc, (k / c_mc) % c_mc});
      @(posedge clock); #1;
      begin
        cexp_t ce;
        ce = cq.pop_front();
        chk("casc_s0", 32'(num0), 32'(ce.n0));
        chk("casc_s1", 32'(num1), 32'(ce.n1));
      end
    end
    chk("casc_end_s0", 32'(num0), 32'd0);
    chk("casc_end_s1", 32'(num1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
